rom_fetch_arbiter: RTL and testbench

Shares the single synchronous program ROM between two requesters: the CPU instruction-fetch port (IF) and a data-read port (DP, used by LOAD-from-ROM and debug readback). It owns the ROM's active-low CE/OE and its address bus, and runs one access at a time. IF has fixed priority, with an anti-starvation override for DP. Each completed access returns one registered 16-bit word plus a valid pulse to the winning requester.

---
 rtl/rom_fetch_arbiter.sv | 131 +++++++++++++
 tb/tb_rom_fetch_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_arbiter.sv
// Shares one synchronous program ROM between instruction fetch (IF) and a data-read
// port (DP): one access at a time, IF priority with a DP anti-starvation override.
module rom_fetch_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int ROM_LAT    = 1,
  parameter int ROM_DEPTH  = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  input  logic              dp_req,
  input  logic [ADDR_W-1:0] dp_addr,
  output logic              dp_gnt,
  output logic              dp_valid,
  output logic [DATA_W-1:0] dp_data,
  output logic              rom_CE,
  output logic              rom_OE,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              oob_flag
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = STARVE_MAX[CNT_W-1:0];
  localparam int              LAT_M1     = ROM_LAT - 1;
  localparam logic [1:0]      LAT_LAST   = LAT_M1[1:0];
  localparam logic [ADDR_W:0] DEPTH      = ROM_DEPTH[ADDR_W:0];

  state_t            state, next_state;
  logic [1:0]        lat_cnt;
  logic              owner_dp;
  logic [ADDR_W-1:0] addr_q;
  logic              oob_q;
  logic [CNT_W-1:0]  starve;
  logic              accept;
  logic              win_dp;
  logic [ADDR_W-1:0] win_addr;
  logic              in_access;
  logic              first_access;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    next_state   = state;
    accept       = 1'b0;
    win_dp       = dp_req && (!if_req || (starve == STARVE_LIM));
    win_addr     = win_dp ? dp_addr : if_addr;
    in_access    = (state == ACCESS);
    first_access = in_access && (lat_cnt == 2'd0);
    case (state)
      IDLE: begin
        if (if_req || dp_req) begin
          accept     = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt == LAT_LAST) next_state = CAPTURE;
      end
      CAPTURE: begin
        if (if_req || dp_req) begin
          accept     = 1'b1;
          next_state = ACCESS;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    // Out-of-range accesses keep the chip deselected but otherwise time normally.
    if_gnt   = first_access && !owner_dp;
    dp_gnt   = first_access && owner_dp;
    rom_CE   = !(in_access && !oob_q);
    rom_OE   = !in_access;
    rom_addr = addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state   <= next_state;
      lat_cnt <= (in_access && next_state == ACCESS) ? lat_cnt + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_dp <= 1'b0;
      addr_q   <= '0;
      oob_q    <= 1'b0;
      starve   <= '0;
      if_data  <= '0;
      dp_data  <= '0;
      if_valid <= 1'b0;
      dp_valid <= 1'b0;
      oob_flag <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dp_valid <= 1'b0;
      if (state == CAPTURE) begin
        if (owner_dp) begin
          dp_data  <= oob_q ? '0 : rom_dout;
          dp_valid <= 1'b1;
        end else begin
          if_data  <= oob_q ? '0 : rom_dout;
          if_valid <= 1'b1;
        end
        if (oob_q) oob_flag <= 1'b1;
      end
      if (accept) begin
        owner_dp <= win_dp;
        addr_q   <= win_addr;
        oob_q    <= ({1'b0, win_addr} >= DEPTH);
      end
      // The starve count only measures IF grants taken while DP is actually waiting.
      if (!dp_req || (accept && win_dp)) starve <= '0;
      else if (accept && starve != STARVE_LIM) starve <= starve + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: vector table, directed corner sequences,
// a ROM_LAT=3 instance, and random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_rom_fetch_arbiter;

  localparam int DEPTH = 256;
  localparam int SMAX  = 4;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req, dp_req, if_gnt, if_valid, dp_gnt, dp_valid;
  logic        rom_ce, rom_oe, oob_flag;
  logic [15:0] if_addr, dp_addr, if_data, dp_data, rom_addr, rom_dout;

  logic        l3_if_req, l3_dp_req, l3_if_gnt, l3_if_valid, l3_dp_gnt, l3_dp_valid;
  logic        l3_ce, l3_oe, l3_oob;
  logic [15:0] l3_if_addr, l3_dp_addr, l3_if_data, l3_dp_data, l3_addr, l3_dout;

  rom_fetch_arbiter #(.ROM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_data(if_data),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_gnt(dp_gnt), .dp_valid(dp_valid), .dp_data(dp_data),
    .rom_CE(rom_ce), .rom_OE(rom_oe), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .oob_flag(oob_flag)
  );

  rom_fetch_arbiter #(.ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt), .if_valid(l3_if_valid),
    .if_data(l3_if_data),
    .dp_req(l3_dp_req), .dp_addr(l3_dp_addr), .dp_gnt(l3_dp_gnt), .dp_valid(l3_dp_valid),
    .dp_data(l3_dp_data),
    .rom_CE(l3_ce), .rom_OE(l3_oe), .rom_addr(l3_addr), .rom_dout(l3_dout),
    .oob_flag(l3_oob)
  );

  // ROM models: mem[i] = A500+i; unimplemented words read as DEAD if ever selected.
  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return (a < 16'(DEPTH)) ? 16'hA500 + a : 16'hDEAD;
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    return (a < 16'(DEPTH)) ? 16'hA500 + a : 16'h0000;
  endfunction

  always @(posedge clk) if (!rom_ce && !rom_oe) rom_dout <= rom_word(rom_addr);

  logic [15:0] p3 [3];
  always @(posedge clk) begin
    if (!l3_ce && !l3_oe) p3[0] <= rom_word(l3_addr);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign l3_dout = p3[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic [15:0] da;
    logic        e_ig;
    logic        e_iv;
    logic [15:0] e_id;
    logic        e_dg;
    logic        e_dv;
    logic [15:0] e_dd;
    logic        e_ce;
    logic        e_oe;
    logic [15:0] e_ra;
  } vec_t;

  vec_t tbl [8];

  // Transaction-level reference model state (edge-indexed).
  int          m_k, m_next_acc, m_acc_edge, m_starve;
  logic [15:0] m_acc_addr;
  bit          m_acc_dp, m_in_acc;
  bit          e_if_gnt, e_dp_gnt, e_if_valid, e_dp_valid, e_oob;
  logic [15:0] e_if_data, e_dp_data;

  task automatic model_edge();
    bit acc;
    bit dp_wins;
    e_if_gnt   = 1'b0;
    e_dp_gnt   = 1'b0;
    e_if_valid = 1'b0;
    e_dp_valid = 1'b0;
    acc        = 1'b0;
    dp_wins    = 1'b0;
    if (m_k == m_acc_edge + LAT + 1) begin
      if (m_acc_dp) begin e_dp_valid = 1'b1; e_dp_data = exp_word(m_acc_addr); end
      else          begin e_if_valid = 1'b1; e_if_data = exp_word(m_acc_addr); end
      if (m_acc_addr >= 16'(DEPTH)) e_oob = 1'b1;
    end
    if (m_k >= m_next_acc && (if_req || dp_req)) begin
      acc        = 1'b1;
      dp_wins    = dp_req && (!if_req || m_starve == SMAX);
      m_acc_edge = m_k;
      m_acc_dp   = dp_wins;
      m_acc_addr = dp_wins ? dp_addr : if_addr;
      m_next_acc = m_k + LAT + 1;
      if (dp_wins) e_dp_gnt = 1'b1;
      else         e_if_gnt = 1'b1;
    end
    if (!dp_req || (acc && dp_wins)) m_starve = 0;
    else if (acc && m_starve < SMAX) m_starve = m_starve + 1;
    m_in_acc = (m_k >= m_acc_edge) && (m_k <= m_acc_edge + LAT - 1);
    m_k++;
  endtask

  function automatic logic [15:0] rnd_addr();
    if ($urandom_range(0, 19) == 0) return 16'($urandom_range(256, 65535));
    return 16'($urandom_range(0, 255));
  endfunction

  int          n, cnt_g, first_v, last_v, gi, dpv, badv;
  logic [7:0]  gseq;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_req = 0; if_addr = 0; dp_req = 0; dp_addr = 0;
    l3_if_req = 0; l3_if_addr = 0; l3_dp_req = 0; l3_dp_addr = 0;

    tbl[0] = '{1'b1, 16'd3, 1'b0, 16'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd3};
    tbl[1] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd0};
    tbl[2] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b1, 16'hA503, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd0};
    tbl[3] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'hA503, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd0};
    tbl[4] = '{1'b0, 16'd0, 1'b1, 16'd7, 1'b0, 1'b0, 16'hA503, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd7};
    tbl[5] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'hA503, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'd0};
    tbl[6] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'hA503, 1'b0, 1'b1, 16'hA507, 1'b1, 1'b1, 16'd0};
    tbl[7] = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 16'hA503, 1'b0, 1'b0, 16'hA507, 1'b1, 1'b1, 16'd0};

    // Reset state.
    @(negedge clk);
    check("rst_if_gnt", if_gnt, 0);   check("rst_dp_gnt", dp_gnt, 0);
    check("rst_ce", rom_ce, 1);       check("rst_oe", rom_oe, 1);
    check("rst_addr", rom_addr, 0);   check("rst_if_data", if_data, 0);
    check("rst_dp_data", dp_data, 0); check("rst_oob", oob_flag, 0);
    @(negedge clk);
    rst = 1'b1;

    // Vector table: single IF read of addr 3, then a single DP read of addr 7.
    for (int i = 0; i < 8; i++) begin
      if_req = tbl[i].ir; if_addr = tbl[i].ia; dp_req = tbl[i].dr; dp_addr = tbl[i].da;
      @(negedge clk);
      check($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].e_ig);
      check($sformatf("tbl%0d_if_valid", i), if_valid, tbl[i].e_iv);
      check($sformatf("tbl%0d_if_data", i), if_data, tbl[i].e_id);
      check($sformatf("tbl%0d_dp_gnt", i), dp_gnt, tbl[i].e_dg);
      check($sformatf("tbl%0d_dp_valid", i), dp_valid, tbl[i].e_dv);
      check($sformatf("tbl%0d_dp_data", i), dp_data, tbl[i].e_dd);
      check($sformatf("tbl%0d_ce", i), rom_ce, tbl[i].e_ce);
      check($sformatf("tbl%0d_oe", i), rom_oe, tbl[i].e_oe);
      if (!tbl[i].e_oe) check($sformatf("tbl%0d_rom_addr", i), rom_addr, tbl[i].e_ra);
    end
    if_req = 0; dp_req = 0;

    // Continuous IF stream over addresses 0..19.
    n = 0; cnt_g = 0; first_v = -1; last_v = -1; dpv = 0;
    if_req = 1; if_addr = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dp_gnt || dp_valid) dpv++;
      if (if_valid) begin
        check("stream_data", if_data, 16'hA500 + n);
        if (first_v < 0) first_v = c;
        last_v = c;
        n++;
      end
      if (if_gnt) begin
        cnt_g++;
        if (cnt_g == 20) if_req = 0;
        else if_addr = 16'(cnt_g);
      end
    end
    check("stream_count", n, 20);
    check("stream_span", last_v - first_v, 38);
    check("stream_dp_quiet", dpv, 0);

    // IF and DP both held: four IF grants, then DP is forced through.
    if_req = 1; if_addr = 8; dp_req = 1; dp_addr = 20;
    gi = 0; gseq = '0; dpv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((if_gnt || dp_gnt) && gi < 8) begin gseq[gi] = dp_gnt; gi++; end
      if (dp_gnt) dp_req = 0;
      if (dp_valid) begin check("starve_dp_data", dp_data, 16'hA514); dpv++; end
      if (if_valid) check("starve_if_data", if_data, 16'hA508);
    end
    if_req = 0;
    check("starve_order", gseq, 8'h10);
    check("starve_dp_count", dpv, 1);
    repeat (4) @(negedge clk);

    // DP read of an unimplemented word, then a legal IF read.
    dp_req = 1; dp_addr = 300;
    @(negedge clk);
    dp_req = 0;
    check("oob_dp_gnt", dp_gnt, 1); check("oob_ce_acc", rom_ce, 1);
    check("oob_oe_acc", rom_oe, 0); check("oob_rom_addr", rom_addr, 300);
    check("oob_flag_early", oob_flag, 0);
    @(negedge clk);
    check("oob_ce_cap", rom_ce, 1); check("oob_valid_early", dp_valid, 0);
    @(negedge clk);
    check("oob_dp_valid", dp_valid, 1); check("oob_dp_data", dp_data, 0);
    check("oob_flag_set", oob_flag, 1);
    if_req = 1; if_addr = 5;
    @(negedge clk);
    if_req = 0;
    check("oob_next_gnt", if_gnt, 1); check("oob_next_ce", rom_ce, 0);
    @(negedge clk);
    @(negedge clk);
    check("oob_next_valid", if_valid, 1); check("oob_next_data", if_data, 16'hA505);
    check("oob_flag_sticky", oob_flag, 1); check("oob_dp_data_held", dp_data, 0);

    // Reset asserted mid-access.
    if_req = 1; if_addr = 9;
    @(negedge clk);
    if_req = 0;
    check("rstmid_gnt_before", if_gnt, 1);
    #1 rst = 1'b0;
    #1;
    check("rstmid_if_gnt", if_gnt, 0);     check("rstmid_ce", rom_ce, 1);
    check("rstmid_oe", rom_oe, 1);         check("rstmid_addr", rom_addr, 0);
    check("rstmid_if_data", if_data, 0);   check("rstmid_dp_data", dp_data, 0);
    check("rstmid_oob", oob_flag, 0);      check("rstmid_if_valid", if_valid, 0);
    badv = 0;
    repeat (2) begin @(negedge clk); if (if_valid) badv++; end
    rst = 1'b1;
    repeat (4) begin @(negedge clk); if (if_valid) badv++; end
    check("rstmid_no_valid", badv, 0);
    if_req = 1; if_addr = 5;
    @(negedge clk);
    if_req = 0;
    check("rstmid_new_gnt", if_gnt, 1);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_new_valid", if_valid, 1); check("rstmid_new_data", if_data, 16'hA505);

    // ROM_LAT=3 instance: DP read of addr 1.
    l3_dp_req = 1; l3_dp_addr = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) l3_dp_req = 0;
      check($sformatf("lat3_ce_%0d", c), l3_ce, (c < 3) ? 1'b0 : 1'b1);
      check($sformatf("lat3_oe_%0d", c), l3_oe, (c < 3) ? 1'b0 : 1'b1);
      if (c < 3) check($sformatf("lat3_addr_%0d", c), l3_addr, 1);
      check($sformatf("lat3_gnt_%0d", c), l3_dp_gnt, c == 0);
      check($sformatf("lat3_valid_%0d", c), l3_dp_valid, c == 4);
      check($sformatf("lat3_if_valid_%0d", c), l3_if_valid, 0);
      if (c == 4) check("lat3_dp_data", l3_dp_data, 16'hA501);
    end

    // Random traffic against the transaction-level model, starting from reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_k = 0; m_next_acc = 0; m_acc_edge = -100; m_starve = 0;
    m_acc_addr = 0; m_acc_dp = 0; e_oob = 0; e_if_data = 0; e_dp_data = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      model_edge();
      check("rnd_if_gnt", if_gnt, e_if_gnt);
      check("rnd_dp_gnt", dp_gnt, e_dp_gnt);
      check("rnd_if_valid", if_valid, e_if_valid);
      check("rnd_dp_valid", dp_valid, e_dp_valid);
      check("rnd_if_data", if_data, e_if_data);
      check("rnd_dp_data", dp_data, e_dp_data);
      check("rnd_oob", oob_flag, e_oob);
      check("rnd_oe", rom_oe, !m_in_acc);
      check("rnd_ce", rom_ce, !m_in_acc || (m_acc_addr >= 16'(DEPTH)));
      if (m_in_acc) check("rnd_rom_addr", rom_addr, m_acc_addr);
      if (!if_req || e_if_gnt) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = rnd_addr();
      end
      if (!dp_req || e_dp_gnt) begin
        dp_req  = ($urandom_range(0, 99) < 40);
        dp_addr = rnd_addr();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
